// File: rtl/pcm_envelope_shaper_pkg.sv
// Shared definitions for the ADSR envelope shaper: state encoding, default widths, rate helper.
package pcm_envelope_shaper_pkg;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_e;

    localparam int PCM_W_DEFAULT    = 16;
    localparam int ENV_W_DEFAULT    = 8;
    localparam int TICK_DIV_DEFAULT = 256;
    localparam int RATE_W           = 4;
    localparam int ENV_MAX          = 2**ENV_W_DEFAULT - 1;

    // A rate code r moves the level by r+1 per tick, so a zero code still makes progress.
    function automatic logic [RATE_W:0] rate_step(input logic [RATE_W-1:0] rate);
        return {1'b0, rate} + (RATE_W+1)'(1);
    endfunction

endpackage

// File: rtl/env_tick_prescaler.sv
// Free-running divider producing a one-cycle envelope step tick every TICK_DIV clocks.
module env_tick_prescaler
    import pcm_envelope_shaper_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int              CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // NOTE: clocked state is only ever written with <= so every flop sees the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + CNT_W'(1);
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/pcm_envelope_shaper.sv
// ADSR envelope generator scaling unsigned PCM samples on their way to the PDM stage.
// Define ENV_GATE_SYNC_EN to pass an asynchronous gate through a 2-flop synchroniser.
module pcm_envelope_shaper
    import pcm_envelope_shaper_pkg::*;
#(
    parameter int PCM_W    = PCM_W_DEFAULT,
    parameter int ENV_W    = ENV_W_DEFAULT,
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gate,
    input  logic [RATE_W-1:0] attack_rate,
    input  logic [RATE_W-1:0] decay_rate,
    input  logic [ENV_W-1:0]  sustain_level,
    input  logic [RATE_W-1:0] release_rate,
    input  logic [PCM_W-1:0]  pcm_in,
    output logic [PCM_W-1:0]  pcm_out,
    output logic [ENV_W-1:0]  env_level,
    output logic [2:0]        env_state
);

    localparam logic [ENV_W-1:0] LEVEL_MAX = '1;
    localparam int               PROD_W    = PCM_W + ENV_W + 1;

    logic             tick;
    logic             gate_q, gate_prev, rise, fall;
    env_state_e       state, state_next;
    logic [ENV_W-1:0] level, level_next;
    logic [ENV_W:0]   level_ext, a_step, d_step, r_step, attack_sum, scale;
    logic [ENV_W-1:0] decay_next, release_next;

    env_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

`ifdef ENV_GATE_SYNC_EN
    logic gate_meta, gate_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            {gate_sync, gate_meta} <= 2'b00;
        else
            {gate_sync, gate_meta} <= {gate_meta, gate};
    end

    assign gate_q = gate_sync;
`else
    assign gate_q = gate;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            gate_prev <= 1'b0;
        else
            gate_prev <= gate_q;
    end

    assign rise = gate_q & ~gate_prev;
    assign fall = ~gate_q & gate_prev;

    // One extra bit of headroom lets every step compare against full scale or zero without wrapping.
    assign level_ext    = {1'b0, level};
    assign a_step       = (ENV_W+1)'(rate_step(attack_rate));
    assign d_step       = (ENV_W+1)'(rate_step(decay_rate));
    assign r_step       = (ENV_W+1)'(rate_step(release_rate));
    assign attack_sum   = level_ext + a_step;
    assign decay_next   = (level_ext >= d_step + {1'b0, sustain_level}) ?
                          level - d_step[ENV_W-1:0] : sustain_level;
    assign release_next = (level_ext > r_step) ? level - r_step[ENV_W-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ENV_IDLE;
            level <= '0;
        end else begin
            state <= state_next;
            level <= level_next;
        end
    end

    // NOTE: hold-current defaults come first so no branch leaves a comb output unassigned (no latch).
    always_comb begin
        state_next = state;
        level_next = level;
        unique case (state)
            ENV_IDLE: begin
                if (rise)
                    state_next = ENV_ATTACK;
            end
            ENV_ATTACK: begin
                if (fall) begin
                    state_next = ENV_RELEASE;
                end else if (tick) begin
                    if (attack_sum >= {1'b0, LEVEL_MAX}) begin
                        level_next = LEVEL_MAX;
                        state_next = ENV_DECAY;
                    end else begin
                        level_next = attack_sum[ENV_W-1:0];
                    end
                end
            end
            ENV_DECAY: begin
                if (fall) begin
                    state_next = ENV_RELEASE;
                end else if (level <= sustain_level) begin
                    state_next = ENV_SUSTAIN;
                end else if (tick) begin
                    level_next = decay_next;
                    if (decay_next == sustain_level)
                        state_next = ENV_SUSTAIN;
                end
            end
            ENV_SUSTAIN: begin
                if (fall)
                    state_next = ENV_RELEASE;
                else
                    level_next = sustain_level;
            end
            ENV_RELEASE: begin
                // A retrigger restarts the attack from wherever the release had got to.
                if (rise) begin
                    state_next = ENV_ATTACK;
                end else if (tick) begin
                    level_next = release_next;
                    if (release_next == '0)
                        state_next = ENV_IDLE;
                end
            end
            default: begin
                state_next = ENV_IDLE;
                level_next = '0;
            end
        endcase
    end

    // level+1 makes full scale an exact unity gain after the ENV_W shift.
    always_comb begin
        env_state = state;
        env_level = level;
        scale     = (level == '0) ? '0 : level_ext + (ENV_W+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pcm_out <= '0;
        else
            pcm_out <= PCM_W'((PROD_W'(pcm_in) * PROD_W'(scale)) >> ENV_W);
    end

endmodule
